// File: rtl/irs_trig_pattern_gen_pkg.sv
// ---------------------------------------------------------------------------
// irs_trig_pattern_gen_pkg
// Shared definitions for the IRS trigger pattern generator.
//   mode_t   : operating mode encodings (single / burst / continuous).
//   state_t  : sequencer state encodings (IDLE / ARM / PULSE / GAP).
//   norm_mode: folds the reserved mode encoding onto single-shot.
// ---------------------------------------------------------------------------
package irs_trig_pattern_gen_pkg;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_BURST  = 2'd1,
        MODE_CONT   = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_PULSE = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // The reserved encoding behaves exactly like a single pulse.
    function automatic mode_t norm_mode(input logic [1:0] i_mode);
        mode_t v_mode;
        case (i_mode)
            2'd1:    v_mode = MODE_BURST;
            2'd2:    v_mode = MODE_CONT;
            default: v_mode = MODE_SINGLE;
        endcase
        return v_mode;
    endfunction

endpackage

// File: rtl/irs_trig_interval_ctr.sv
// ---------------------------------------------------------------------------
// irs_trig_interval_ctr
// Loadable down-counter with zero flag, used to time pulse width and gap.
// Ports:
//   clk_i   : clock
//   rst_i   : synchronous active-high reset (count -> 0)
//   load_i  : load value_i (has priority over dec_i)
//   value_i : load value
//   dec_i   : decrement by one, stops at zero
//   zero_o  : count is zero
// ---------------------------------------------------------------------------
module irs_trig_interval_ctr #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] r_count;

    // Count register: load, decrement toward zero, or hold.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (load_i) begin
            r_count <= value_i;
        end else if (dec_i && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign zero_o = (r_count == '0);

endmodule

// File: rtl/irs_trig_pattern_gen.sv
// ---------------------------------------------------------------------------
// irs_trig_pattern_gen
// Trigger stimulus generator for the irs_quad_top trigger inputs. Issues a
// single pulse, a counted burst or continuous pulses with programmable
// width, period and L4 mask; holds off new pulses while busy_i is high.
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   start_i, stop_i     : single-cycle start / abort requests
//   mode_i              : 0 single, 1 burst, 2 continuous, 3 = single
//   l4_mask_i, width_i, period_i, count_i, offset_i : config, latched at start
//   busy_i              : downstream busy, holds the sequencer in ARM
//   trig_o, trig_l4_o, trig_l4_new_o, trig_offset_o : trigger outputs
//   active_o, done_o, sent_o                        : status
// ---------------------------------------------------------------------------
module irs_trig_pattern_gen
    import irs_trig_pattern_gen_pkg::*;
#(
    parameter int NUM_L4      = 4,
    parameter int WIDTH_BITS  = 4,
    parameter int PERIOD_BITS = 16,
    parameter int COUNT_BITS  = 16,
    parameter int OFFSET_BITS = 9
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic [1:0]             mode_i,
    input  logic [NUM_L4-1:0]      l4_mask_i,
    input  logic [WIDTH_BITS-1:0]  width_i,
    input  logic [PERIOD_BITS-1:0] period_i,
    input  logic [COUNT_BITS-1:0]  count_i,
    input  logic [OFFSET_BITS-1:0] offset_i,
    input  logic                   busy_i,
    output logic                   trig_o,
    output logic [NUM_L4-1:0]      trig_l4_o,
    output logic [NUM_L4-1:0]      trig_l4_new_o,
    output logic [OFFSET_BITS-1:0] trig_offset_o,
    output logic                   active_o,
    output logic                   done_o,
    output logic [COUNT_BITS-1:0]  sent_o
);

    state_t                 r_state;
    mode_t                  r_mode;
    logic [NUM_L4-1:0]      r_mask;
    logic [WIDTH_BITS-1:0]  r_width;
    logic [PERIOD_BITS-1:0] r_period;
    logic [COUNT_BITS-1:0]  r_count;
    logic                   r_pend;
    logic                   r_trig;
    logic [NUM_L4-1:0]      r_l4;
    logic [NUM_L4-1:0]      r_l4_new;
    logic [OFFSET_BITS-1:0] r_offset;
    logic                   r_active;
    logic                   r_done;
    logic [COUNT_BITS-1:0]  r_sent;

    logic [WIDTH_BITS-1:0]  w_width_eff;
    logic [PERIOD_BITS-1:0] w_width_ext;
    logic [PERIOD_BITS-1:0] w_period_eff;
    logic [PERIOD_BITS-1:0] w_gap_len;
    logic                   w_fire;
    logic                   w_last;
    logic                   w_target;
    logic                   w_finish;
    logic                   w_gap_load;
    logic                   w_wid_zero;
    logic                   w_gap_zero;

    function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] i_v);
        if (i_v == '1) begin
            return i_v;
        end else begin
            return i_v + COUNT_BITS'(1);
        end
    endfunction

    // Effective width W = max(width,1); period clamped so the gap is never negative.
    assign w_width_eff  = (r_width == '0) ? WIDTH_BITS'(1) : r_width;
    assign w_width_ext  = PERIOD_BITS'(w_width_eff);
    assign w_period_eff = (r_period > w_width_ext) ? r_period : (w_width_ext + PERIOD_BITS'(1));
    assign w_gap_len    = w_period_eff - w_width_ext - PERIOD_BITS'(1);

    assign w_fire     = (r_state == ST_ARM) && !stop_i && !busy_i;
    assign w_last     = (r_state == ST_PULSE) && w_wid_zero;
    assign w_finish   = w_last && (w_target || r_pend || stop_i);
    assign w_gap_load = w_last && !w_finish && (w_gap_len != '0);

    // Pulse target: sent_o already counts the current pulse while it is high.
    always_comb begin
        w_target = 1'b0;
        case (r_mode)
            MODE_SINGLE: w_target = 1'b1;
            MODE_BURST:  w_target = (r_sent == r_count);
            default:     w_target = 1'b0;
        endcase
    end

    irs_trig_interval_ctr #(.W(WIDTH_BITS)) u_width_ctr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (w_fire),
        .value_i (w_width_eff - WIDTH_BITS'(1)),
        .dec_i   (r_state == ST_PULSE),
        .zero_o  (w_wid_zero)
    );

    irs_trig_interval_ctr #(.W(PERIOD_BITS)) u_gap_ctr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (w_gap_load),
        .value_i (w_gap_len - PERIOD_BITS'(1)),
        .dec_i   (r_state == ST_GAP),
        .zero_o  (w_gap_zero)
    );

    // Sequencer with all outputs registered alongside the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_mode   <= MODE_SINGLE;
            r_mask   <= '0;
            r_width  <= '0;
            r_period <= '0;
            r_count  <= '0;
            r_pend   <= 1'b0;
            r_trig   <= 1'b0;
            r_l4     <= '0;
            r_l4_new <= '0;
            r_offset <= '0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
            r_sent   <= '0;
        end else begin
            r_done   <= 1'b0;
            r_l4_new <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_mode   <= norm_mode(mode_i);
                        r_mask   <= l4_mask_i;
                        r_width  <= width_i;
                        r_period <= period_i;
                        r_count  <= count_i;
                        r_offset <= offset_i;
                        r_sent   <= '0;
                        r_pend   <= 1'b0;
                        // An empty burst completes immediately without arming.
                        if ((norm_mode(mode_i) == MODE_BURST) && (count_i == '0)) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state  <= ST_ARM;
                            r_active <= 1'b1;
                        end
                    end
                end
                ST_ARM: begin
                    if (stop_i) begin
                        r_state  <= ST_IDLE;
                        r_active <= 1'b0;
                        r_done   <= 1'b1;
                    end else if (!busy_i) begin
                        r_state  <= ST_PULSE;
                        r_trig   <= 1'b1;
                        r_l4     <= r_mask;
                        r_l4_new <= r_mask;
                        r_sent   <= sat_inc(r_sent);
                    end
                end
                ST_PULSE: begin
                    if (w_finish) begin
                        r_state  <= ST_IDLE;
                        r_trig   <= 1'b0;
                        r_l4     <= '0;
                        r_active <= 1'b0;
                        r_done   <= 1'b1;
                        r_pend   <= 1'b0;
                    end else if (w_last) begin
                        r_trig  <= 1'b0;
                        r_l4    <= '0;
                        r_state <= (w_gap_len == '0) ? ST_ARM : ST_GAP;
                    end else if (stop_i) begin
                        // Abort is deferred so the pulse is never truncated.
                        r_pend <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (stop_i) begin
                        r_state  <= ST_IDLE;
                        r_active <= 1'b0;
                        r_done   <= 1'b1;
                    end else if (w_gap_zero) begin
                        r_state <= ST_ARM;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign trig_o        = r_trig;
    assign trig_l4_o     = r_l4;
    assign trig_l4_new_o = r_l4_new;
    assign trig_offset_o = r_offset;
    assign active_o      = r_active;
    assign done_o        = r_done;
    assign sent_o        = r_sent;

endmodule

// File: tb/tb_irs_trig_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_irs_trig_pattern_gen
// Self-checking bench: a time-based reference model (pulse rise times,
// earliest-next-rise, issued-pulse count) predicts every output each cycle;
// directed scenarios additionally check rise spacing and done timing.
// ---------------------------------------------------------------------------
module tb_irs_trig_pattern_gen;

    logic       clk = 1'b0;
    logic       rst, start, stop, busy;
    logic [1:0] mode;
    logic [3:0] mask;
    logic [3:0] width;
    logic [15:0] period, count;
    logic [8:0] offset;

    logic       trig_o, active_o, done_o;
    logic [3:0] trig_l4_o, trig_l4_new_o;
    logic [8:0] trig_offset_o;
    logic [15:0] sent_o;

    always #5 clk = ~clk;

    irs_trig_pattern_gen dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
        .mode_i(mode), .l4_mask_i(mask), .width_i(width), .period_i(period),
        .count_i(count), .offset_i(offset), .busy_i(busy),
        .trig_o(trig_o), .trig_l4_o(trig_l4_o), .trig_l4_new_o(trig_l4_new_o),
        .trig_offset_o(trig_offset_o), .active_o(active_o), .done_o(done_o),
        .sent_o(sent_o)
    );

    int total = 0;
    int bad   = 0;
    int c     = 0;

    // reference model state
    bit         m_run, m_have, m_pend;
    int         m_rise, m_earliest, m_n, m_W, m_P, m_count;
    logic [1:0] m_mode;
    logic [3:0] m_mask;
    logic [8:0] m_off;
    logic       e_trig, e_done, e_active;
    logic [3:0] e_l4, e_l4_new;
    logic [15:0] e_sent;

    int  q_rise[$];
    int  q_done[$];
    int  hi_cnt;
    logic prev_trig = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, c, got, exp);
        end
    endtask

    function automatic int qa(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Advance the model by one clock using the inputs of the current cycle.
    task automatic model_step();
        bit in_p;
        e_done = 1'b0;
        if (rst) begin
            m_run = 0; m_have = 0; m_pend = 0; m_n = 0; m_off = 9'd0;
        end else if (!m_run) begin
            if (start) begin
                m_mode  = (mode == 2'd3) ? 2'd0 : mode;
                m_mask  = mask;
                m_W     = (width == 4'd0) ? 1 : int'(width);
                m_P     = (int'(period) > m_W) ? int'(period) : m_W + 1;
                m_count = int'(count);
                m_off   = offset;
                m_n = 0; m_have = 0; m_pend = 0;
                if (m_mode == 2'd1 && count == 16'd0) begin
                    e_done = 1'b1;
                end else begin
                    m_run = 1; m_earliest = c + 2;
                end
            end
        end else begin
            in_p = m_have && (c < m_rise + m_W);
            if (in_p) begin
                if (stop) m_pend = 1;
                if (c == m_rise + m_W - 1) begin
                    if (m_pend || m_mode == 2'd0 || (m_mode == 2'd1 && m_n >= m_count)) begin
                        m_run = 0; e_done = 1'b1;
                    end else begin
                        m_earliest = m_rise + m_P;
                    end
                end
            end else if (stop) begin
                m_run = 0; e_done = 1'b1;
            end else if (c + 1 >= m_earliest && !busy) begin
                m_rise = c + 1; m_have = 1; m_n++;
            end
        end
        e_trig   = m_run && m_have && (c + 1 >= m_rise) && (c + 1 < m_rise + m_W);
        e_l4     = e_trig ? m_mask : 4'd0;
        e_l4_new = (e_trig && (c + 1 == m_rise)) ? m_mask : 4'd0;
        e_active = m_run;
        e_sent   = (m_n > 65535) ? 16'hFFFF : 16'(m_n);
    endtask

    task automatic tick(input logic st, input logic sp, input logic bz, input logic rs);
        start = st; stop = sp; busy = bz; rst = rs;
        model_step();
        @(negedge clk);
        c++;
        check("trig",    trig_o,        e_trig);
        check("l4",      trig_l4_o,     e_l4);
        check("l4_new",  trig_l4_new_o, e_l4_new);
        check("done",    done_o,        e_done);
        check("active",  active_o,      e_active);
        check("sent",    sent_o,        e_sent);
        check("offset",  trig_offset_o, m_off);
        if (trig_o && !prev_trig) q_rise.push_back(c);
        if (done_o) q_done.push_back(c);
        if (trig_o) hi_cnt++;
        prev_trig = trig_o;
    endtask

    task automatic cfg(input logic [1:0] md, input logic [3:0] w, input logic [15:0] p,
                       input logic [15:0] n, input logic [3:0] mk, input logic [8:0] off);
        mode = md; width = w; period = p; count = n; mask = mk; offset = off;
        q_rise.delete(); q_done.delete(); hi_cnt = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    int s;

    initial begin
        cfg(2'd0, 4'd0, 16'd0, 16'd0, 4'd0, 9'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        check("reset_trig", trig_o, 1'b0);
        check("reset_sent", sent_o, 16'd0);
        idle(3);

        // single pulse, width 3
        cfg(2'd0, 4'd3, 16'd0, 16'd0, 4'hF, 9'h1A5);
        s = c; tick(1'b1, 1'b0, 1'b0, 1'b0); idle(10);
        check("single_nrise", q_rise.size(), 1);
        check("single_rise", qa(q_rise, 0) - s, 2);
        check("single_width", hi_cnt, 3);
        check("single_done", qa(q_done, 0) - s, 5);
        check("single_sent", sent_o, 16'd1);

        // burst of 4, width 2, period 10
        cfg(2'd1, 4'd2, 16'd10, 16'd4, 4'h5, 9'h033);
        s = c; tick(1'b1, 1'b0, 1'b0, 1'b0); idle(50);
        check("burst_nrise", q_rise.size(), 4);
        check("burst_rise0", qa(q_rise, 0) - s, 2);
        for (int i = 1; i < 4; i++) check("burst_space", qa(q_rise, i) - qa(q_rise, i - 1), 10);
        check("burst_done", qa(q_done, 0) - s, 34);
        check("burst_sent", sent_o, 16'd4);

        // empty burst
        cfg(2'd1, 4'd2, 16'd10, 16'd0, 4'h3, 9'h011);
        s = c; tick(1'b1, 1'b0, 1'b0, 1'b0); idle(5);
        check("cnt0_nrise", q_rise.size(), 0);
        check("cnt0_done", qa(q_done, 0) - s, 1);

        // period clamp: width 5, period 2
        cfg(2'd1, 4'd5, 16'd2, 16'd3, 4'h9, 9'h044);
        s = c; tick(1'b1, 1'b0, 1'b0, 1'b0); idle(30);
        check("clamp_space1", qa(q_rise, 1) - qa(q_rise, 0), 6);
        check("clamp_space2", qa(q_rise, 2) - qa(q_rise, 1), 6);
        check("clamp_high", hi_cnt, 15);

        // width 0 means 1-cycle pulses
        cfg(2'd1, 4'd0, 16'd3, 16'd3, 4'h2, 9'h055);
        s = c; tick(1'b1, 1'b0, 1'b0, 1'b0); idle(20);
        check("w0_high", hi_cnt, 3);
        check("w0_space", qa(q_rise, 1) - qa(q_rise, 0), 3);

        // busy holdoff: busy high for 20 cycles after the first pulse
        cfg(2'd1, 4'd2, 16'd8, 16'd3, 4'hC, 9'h066);
        s = c; tick(1'b1, 1'b0, 1'b0, 1'b0); idle(3);
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 1'b1, 1'b0);
        idle(30);
        check("busy_rise1", qa(q_rise, 1) - s, 25);
        check("busy_space", qa(q_rise, 2) - qa(q_rise, 1), 8);
        check("busy_nrise", q_rise.size(), 3);

        // stop in the second cycle of a continuous pulse
        cfg(2'd2, 4'd4, 16'd10, 16'd0, 4'h7, 9'h077);
        s = c; tick(1'b1, 1'b0, 1'b0, 1'b0); idle(2);
        tick(1'b0, 1'b1, 1'b0, 1'b0); idle(20);
        check("stopp_high", hi_cnt, 4);
        check("stopp_done", qa(q_done, 0) - s, 6);

        // stop during the gap
        cfg(2'd2, 4'd2, 16'd10, 16'd0, 4'h1, 9'h088);
        s = c; tick(1'b1, 1'b0, 1'b0, 1'b0); idle(4);
        tick(1'b0, 1'b1, 1'b0, 1'b0); idle(20);
        check("stopg_nrise", q_rise.size(), 1);
        check("stopg_done", qa(q_done, 0) - s, 6);

        // reset in the middle of a pulse, with start held high
        cfg(2'd1, 4'd4, 16'd10, 16'd4, 4'hB, 9'h099);
        s = c; tick(1'b1, 1'b0, 1'b0, 1'b0); idle(3);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        check("rst_trig", trig_o, 1'b0);
        check("rst_sent", sent_o, 16'd0);
        check("rst_active", active_o, 1'b0);
        q_rise.delete(); q_done.delete();
        idle(20);
        check("rst_nodone", q_done.size(), 0);
        check("rst_nrise", q_rise.size(), 0);

        // randomized traffic; config changes every cycle and must be ignored
        for (int i = 0; i < 4000; i++) begin
            mode   = 2'($urandom_range(0, 3));
            width  = 4'($urandom_range(0, 15));
            period = 16'($urandom_range(0, 24));
            count  = 16'($urandom_range(0, 5));
            mask   = 4'($urandom);
            offset = 9'($urandom);
            tick(1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 49) == 0),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 499) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
